// File: rtl/fifo_pkg.sv
// Shared constants and FSM encoding for the 6-entry x 8-bit switch FIFO.
package fifo_pkg;

    localparam int MAIN_SIZE      = 6;
    localparam int DATA_SIZE      = 8;
    localparam int CNT_W          = 3;
    localparam int AF_THRESH_DEF  = 4;
    localparam int AE_THRESH_DEF  = 1;

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        PARTIAL = 2'b01,
        FULL    = 2'b10
    } fifo_state_e;

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Registered memory index that advances on enable and wraps at DEPTH-1.
// DEPTH need not be a power of two, so the wrap is an explicit compare.
module fifo_ptr_wrap #(
    parameter int W     = 6,
    parameter int DEPTH = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] ptr
);

    localparam logic [W-1:0] LAST = W'(DEPTH - 1);

    // Advance by one per accepted operation, folding LAST back to 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ptr <= '0;
        else if (en)
            ptr <= (ptr == LAST) ? '0 : ptr + W'(1);
    end

endmodule

// File: rtl/fifo_ctrl_6x8.sv
// Pointer/flag controller for the 6x8 storage memory (combinational read,
// registered write). Turns push/pop requests into memory strobes, tracks
// occupancy and reports full/empty, thresholds and rejected requests.
module fifo_ctrl_6x8
    import fifo_pkg::*;
#(
    parameter int MAIN_SIZE = fifo_pkg::MAIN_SIZE,
    parameter int AF_THRESH = fifo_pkg::AF_THRESH_DEF,
    parameter int AE_THRESH = fifo_pkg::AE_THRESH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    output logic                 mem_write,
    output logic                 mem_read,
    output logic [MAIN_SIZE-1:0] wr_ptr,
    output logic [MAIN_SIZE-1:0] rd_ptr,
    output logic [fifo_pkg::CNT_W-1:0] count,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int CNT_W = fifo_pkg::CNT_W;

    fifo_state_e      state;
    fifo_state_e      state_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             push_ok;
    logic             pop_ok;

    // Flags come only from registered state/count, so they never glitch.
    assign fifo_full    = (state == FULL);
    assign fifo_empty   = (state == EMPTY);
    assign almost_full  = (count >= CNT_W'(AF_THRESH));
    assign almost_empty = (count <= CNT_W'(AE_THRESH));

    // A pop frees a slot in the same cycle, so push into a full FIFO is fine
    // alongside an accepted pop. Pop into an empty FIFO never falls through.
    assign pop_ok    = pop & ~fifo_empty;
    assign push_ok   = push & (~fifo_full | pop_ok);
    assign mem_write = push_ok;
    assign mem_read  = pop_ok;

    // Next occupancy and the FSM state it implies.
    always_comb begin
        count_nxt = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
        if (count_nxt == '0)
            state_nxt = EMPTY;
        else if (count_nxt == CNT_W'(MAIN_SIZE))
            state_nxt = FULL;
        else
            state_nxt = PARTIAL;
    end

    // FSM, occupancy and one-cycle reject pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= EMPTY;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            overflow  <= push & ~push_ok;
            underflow <= pop & ~pop_ok;
        end
    end

    fifo_ptr_wrap #(.W(MAIN_SIZE), .DEPTH(MAIN_SIZE)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (push_ok),
        .ptr   (wr_ptr)
    );

    fifo_ptr_wrap #(.W(MAIN_SIZE), .DEPTH(MAIN_SIZE)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (pop_ok),
        .ptr   (rd_ptr)
    );

endmodule

// File: tb/tb_fifo_ctrl_6x8.sv
// Directed bench for fifo_ctrl_6x8 with a behavioural 6x8 memory attached.
module tb_fifo_ctrl_6x8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       mem_write, mem_read;
    logic [5:0] wr_ptr, rd_ptr;
    logic [2:0] count;
    logic       fifo_full, fifo_empty, almost_full, almost_empty;
    logic       overflow, underflow;

    logic [7:0] mem [6];
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fifo_ctrl_6x8 dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .count        (count),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Storage array: registered write, combinational read.
    always @(posedge clk) if (mem_write && wr_ptr < 6) mem[wr_ptr] <= wdata;
    assign rdata = (rd_ptr < 6) ? mem[rd_ptr] : 8'hxx;

    always @(posedge clk)
        if (reset) assert (!$isunknown({push, pop})) else $error("push/pop unknown");

    task automatic test_reset();
        reset = 1'b0; push = 1'b0; pop = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        nvec++; if (wr_ptr !== 6'd0 || rd_ptr !== 6'd0) begin nerr++;
            $display("FAIL reset_ptrs: wr=%0d rd=%0d want 0/0", wr_ptr, rd_ptr); end
        nvec++; if (count !== 3'd0) begin nerr++;
            $display("FAIL reset_count: got %0d want 0", count); end
        nvec++; if ({fifo_empty, almost_empty} !== 2'b11) begin nerr++;
            $display("FAIL reset_empty_flags: got %b want 11", {fifo_empty, almost_empty}); end
        nvec++; if ({fifo_full, almost_full, overflow, underflow} !== 4'b0000) begin nerr++;
            $display("FAIL reset_other_flags: got %b want 0000",
                     {fifo_full, almost_full, overflow, underflow}); end
        @(negedge clk);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 6; i++) begin
            push = 1'b1; wdata = 8'h10 + 8'(i); #1;
            nvec++; if (mem_write !== 1'b1) begin nerr++;
                $display("FAIL fill_wstrobe[%0d]: got %b want 1", i, mem_write); end
            @(posedge clk); #1;
            nvec++; if (count !== 3'(i + 1)) begin nerr++;
                $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
            nvec++; if (almost_full !== (i >= 3)) begin nerr++;
                $display("FAIL fill_af[%0d]: got %b want %b", i, almost_full, i >= 3); end
            nvec++; if (fifo_full !== (i == 5)) begin nerr++;
                $display("FAIL fill_full[%0d]: got %b want %b", i, fifo_full, i == 5); end
            nvec++; if (wr_ptr !== 6'((i + 1) % 6)) begin nerr++;
                $display("FAIL fill_wrptr[%0d]: got %0d want %0d", i, wr_ptr, (i + 1) % 6); end
            @(negedge clk);
        end
        push = 1'b1; wdata = 8'hEE; #1;
        nvec++; if (mem_write !== 1'b0) begin nerr++;
            $display("FAIL ovf_wstrobe: got %b want 0", mem_write); end
        @(posedge clk); #1;
        nvec++; if (overflow !== 1'b1 || wr_ptr !== 6'd0 || count !== 3'd6) begin nerr++;
            $display("FAIL ovf_pulse: ovf=%b wr=%0d cnt=%0d want 1/0/6", overflow, wr_ptr, count); end
        @(negedge clk); push = 1'b0;
        @(posedge clk); #1;
        nvec++; if (overflow !== 1'b0) begin nerr++;
            $display("FAIL ovf_one_cycle: got %b want 0", overflow); end
        @(negedge clk);
    endtask

    task automatic test_drain();
        for (int i = 0; i < 6; i++) begin
            pop = 1'b1; #1;
            nvec++; if (mem_read !== 1'b1 || rd_ptr !== 6'(i)) begin nerr++;
                $display("FAIL drain_rstrobe[%0d]: rd=%b ptr=%0d want 1/%0d", i, mem_read, rd_ptr, i); end
            nvec++; if (rdata !== 8'h10 + 8'(i)) begin nerr++;
                $display("FAIL drain_data[%0d]: got %h want %h", i, rdata, 8'h10 + 8'(i)); end
            @(posedge clk); #1;
            nvec++; if (rd_ptr !== 6'((i + 1) % 6) || count !== 3'(5 - i)) begin nerr++;
                $display("FAIL drain_state[%0d]: ptr=%0d cnt=%0d want %0d/%0d",
                         i, rd_ptr, count, (i + 1) % 6, 5 - i); end
            nvec++; if (fifo_empty !== (i == 5) || almost_empty !== (i >= 4)) begin nerr++;
                $display("FAIL drain_flags[%0d]: e=%b ae=%b want %b/%b",
                         i, fifo_empty, almost_empty, i == 5, i >= 4); end
            @(negedge clk);
        end
        pop = 1'b1; #1;
        nvec++; if (mem_read !== 1'b0) begin nerr++;
            $display("FAIL udf_rstrobe: got %b want 0", mem_read); end
        @(posedge clk); #1;
        nvec++; if (underflow !== 1'b1 || rd_ptr !== 6'd0) begin nerr++;
            $display("FAIL udf_pulse: udf=%b rd=%0d want 1/0", underflow, rd_ptr); end
        @(negedge clk); pop = 1'b0;
        @(posedge clk); #1;
        nvec++; if (underflow !== 1'b0) begin nerr++;
            $display("FAIL udf_one_cycle: got %b want 0", underflow); end
        @(negedge clk);
    endtask

    // Pointers start at 0/0; 8 pushes and 8 pops, occupancy held at 1..2.
    task automatic test_interleave();
        logic [9:0] push_v = 10'b0011111111; // bit c = cycle c
        logic [9:0] pop_v  = 10'b1111111100;
        int np = 0, nq = 0;
        for (int c = 0; c < 10; c++) begin
            push = push_v[c]; pop = pop_v[c]; wdata = 8'hA0 + 8'(np); #1;
            if (pop_v[c]) begin
                nvec++; if (rdata !== 8'hA0 + 8'(nq)) begin nerr++;
                    $display("FAIL ilv_data[%0d]: got %h want %h", c, rdata, 8'hA0 + 8'(nq)); end
            end
            @(posedge clk); #1;
            np += int'(push_v[c]); nq += int'(pop_v[c]);
            nvec++; if (wr_ptr !== 6'(np % 6) || rd_ptr !== 6'(nq % 6) || count !== 3'(np - nq)) begin
                nerr++;
                $display("FAIL ilv_state[%0d]: wr=%0d rd=%0d cnt=%0d want %0d/%0d/%0d",
                         c, wr_ptr, rd_ptr, count, np % 6, nq % 6, np - nq); end
            @(negedge clk);
        end
        push = 1'b0; pop = 1'b0;
    endtask

    // Pointers start at 2/2 with the FIFO empty.
    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            push = 1'b1; wdata = 8'h50 + 8'(i);
            @(negedge clk);
        end
        push = 1'b1; pop = 1'b1; wdata = 8'h77; #1;
        nvec++; if ({mem_write, mem_read} !== 2'b11 || rdata !== 8'h50) begin nerr++;
            $display("FAIL full_both_strobes: w/r=%b data=%h want 11/50", {mem_write, mem_read}, rdata); end
        @(posedge clk); #1;
        nvec++; if (count !== 3'd6 || overflow !== 1'b0 || fifo_full !== 1'b1) begin nerr++;
            $display("FAIL full_both_state: cnt=%0d ovf=%b full=%b want 6/0/1", count, overflow, fifo_full); end
        nvec++; if (wr_ptr !== 6'd3 || rd_ptr !== 6'd3) begin nerr++;
            $display("FAIL full_both_ptrs: wr=%0d rd=%0d want 3/3", wr_ptr, rd_ptr); end
        @(negedge clk);
        push = 1'b0; pop = 1'b1;
        repeat (6) @(negedge clk);
        push = 1'b1; pop = 1'b1; #1;
        nvec++; if ({mem_write, mem_read} !== 2'b10) begin nerr++;
            $display("FAIL empty_both_strobes: got %b want 10", {mem_write, mem_read}); end
        @(posedge clk); #1;
        nvec++; if (underflow !== 1'b1 || count !== 3'd1 || fifo_empty !== 1'b0) begin nerr++;
            $display("FAIL empty_both_state: udf=%b cnt=%0d e=%b want 1/1/0", underflow, count, fifo_empty); end
        @(negedge clk);
        push = 1'b0; pop = 1'b0;
    endtask

    task automatic test_async_reset();
        push = 1'b1;
        repeat (3) @(negedge clk);
        push = 1'b0; pop = 1'b1;
        #2 reset = 1'b0;
        #1;
        nvec++; if (count !== 3'd0 || wr_ptr !== 6'd0 || rd_ptr !== 6'd0) begin nerr++;
            $display("FAIL async_rst_state: cnt=%0d wr=%0d rd=%0d want 0/0/0", count, wr_ptr, rd_ptr); end
        nvec++; if ({fifo_empty, almost_empty, almost_full, mem_read} !== 4'b1100) begin nerr++;
            $display("FAIL async_rst_flags: got %b want 1100",
                     {fifo_empty, almost_empty, almost_full, mem_read}); end
        pop = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_interleave();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time %0t exceeded budget", $time);
        $fatal(1, "timeout");
    end

endmodule
